// File: rtl/ay_bus_sched_pkg.sv
// Shared types and constants for the TurboSound YM2149 bus scheduler.
package ay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESTORE
  } ay_sched_state_t;

  typedef enum logic [1:0] {
    OP_A_ADDR,
    OP_A_DATA,
    OP_B,
    OP_MUTE
  } ay_op_kind_t;

  localparam logic [3:0] AY_REG_VOL_A = 4'd8;
  localparam logic [3:0] AY_REG_VOL_B = 4'd9;
  localparam logic [3:0] AY_REG_VOL_C = 4'd10;

  // "reg" is reserved in SystemVerilog, so the register-number field is rnum.
  typedef struct packed {
    logic        sel;
    logic [3:0]  rnum;
    logic [7:0]  data;
    ay_op_kind_t kind;
  } ay_op_t;

endpackage

// File: rtl/ay_bus_sched_mute_seq.sv
// Mute sequencer: on a mute_req rising edge, requests six volume-zero writes
// (chip0 R8..R10, then chip1 R8..R10) through the scheduler's mute slot.
module ay_mute_seq
  import ay_pkg::*;
(
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       mute_req,
  input  logic       gnt,
  input  logic       ack,
  output logic       pend,
  output logic       sel,
  output logic [3:0] rnum
);

  logic       mreq_q;
  logic [2:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       inflight_q, inflight_d;
  logic       stale_q, stale_d;
  logic       rise;

  assign rise = mute_req & ~mreq_q;

  always_comb begin
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    inflight_d = inflight_q;
    stale_d    = stale_q;
    if (gnt) inflight_d = 1'b1;
    if (ack) begin
      inflight_d = 1'b0;
      stale_d    = 1'b0;
      if (!stale_q) begin
        if (cnt_q == 3'd5) pend_d = 1'b0;
        else               cnt_d  = cnt_q + 3'd1;
      end
    end
    // A restart must not let the ack of a write from the old run advance the new count.
    if (rise) begin
      cnt_d   = '0;
      pend_d  = 1'b1;
      stale_d = (inflight_q & ~ack) | gnt;
    end
  end

  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      mreq_q     <= 1'b0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      inflight_q <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      mreq_q     <= mute_req;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      inflight_q <= inflight_d;
      stale_q    <= stale_d;
    end
  end

  always_comb begin
    sel = (cnt_q >= 3'd3);
    unique case (cnt_q)
      3'd1, 3'd4: rnum = AY_REG_VOL_B;
      3'd2, 3'd5: rnum = AY_REG_VOL_C;
      default:    rnum = AY_REG_VOL_A;
    endcase
  end

  assign pend = pend_q;

endmodule

// File: rtl/ay_bus_sched.sv
// Register-write scheduler sharing the two YM2149 bus-control ports between the
// CPU (priority) and an internal requester. Optional mute engine: AY_MUTE_EN.
module ay_bus_sched
  import ay_pkg::*;
(
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       en,
  input  logic       req_a,
  input  logic       a_sel,
  input  logic       a_is_addr,
  input  logic [7:0] a_d,
  output logic       ack_a,
  input  logic       req_b,
  input  logic       b_sel,
  input  logic [3:0] b_reg,
  input  logic [7:0] b_data,
  output logic       ack_b,
  input  logic       mute_req,
  output logic [7:0] ay_da,
  output logic       ay_addr0,
  output logic       ay_addr1,
  output logic       ay_we0,
  output logic       ay_we1,
  output logic       busy
);

  ay_sched_state_t state_q, state_d;
  ay_op_t          op_q, op_d;
  logic [3:0]      cpu_reg0_q, cpu_reg0_d, cpu_reg1_q, cpu_reg1_d;
  logic            ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic [3:0]      shadow_sel;
  logic            addr_s, we_s, b_done;
  logic            mute_pend, mute_sel, mute_gnt, mute_ack;
  logic [3:0]      mute_rnum;

`ifdef AY_MUTE_EN
  ay_mute_seq u_mute (
    .clk28    (clk28),
    .rst_n    (rst_n),
    .mute_req (mute_req),
    .gnt      (mute_gnt),
    .ack      (mute_ack),
    .pend     (mute_pend),
    .sel      (mute_sel),
    .rnum     (mute_rnum)
  );
  assign busy = (state_q != ST_IDLE) | mute_pend;
`else
  assign mute_pend = 1'b0;
  assign mute_sel  = 1'b0;
  assign mute_rnum = '0;
  logic unused_mute;
  assign unused_mute = mute_req ^ mute_gnt ^ mute_ack;
  assign busy = (state_q != ST_IDLE);
`endif

  assign shadow_sel = op_q.sel ? cpu_reg1_q : cpu_reg0_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cpu_reg0_d = cpu_reg0_q;
    cpu_reg1_d = cpu_reg1_q;
    ack_a_d    = 1'b0;
    ack_b_d    = 1'b0;
    mute_gnt   = 1'b0;
    mute_ack   = 1'b0;
    b_done     = 1'b0;
    addr_s     = 1'b0;
    we_s       = 1'b0;
    ay_da      = 8'hFF;
    unique case (state_q)
      ST_IDLE: begin
        if (req_a) begin
          op_d.sel  = a_sel;
          op_d.rnum = a_d[3:0];
          op_d.data = a_d;
          op_d.kind = a_is_addr ? OP_A_ADDR : OP_A_DATA;
          state_d   = a_is_addr ? ST_ADDR : ST_DATA;
        end else if (mute_pend) begin
          op_d.sel  = mute_sel;
          op_d.rnum = mute_rnum;
          op_d.data = 8'h00;
          op_d.kind = OP_MUTE;
          mute_gnt  = 1'b1;
          state_d   = ST_ADDR;
        end else if (req_b) begin
          op_d.sel  = b_sel;
          op_d.rnum = b_reg;
          op_d.data = b_data;
          op_d.kind = OP_B;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        ay_da  = {4'h0, op_q.rnum};
        addr_s = 1'b1;
        if (en) begin
          if (op_q.kind == OP_A_ADDR) begin
            if (op_q.sel) cpu_reg1_d = op_q.rnum;
            else          cpu_reg0_d = op_q.rnum;
            ack_a_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        ay_da = op_q.data;
        we_s  = 1'b1;
        if (en) begin
          if (op_q.kind == OP_A_DATA) begin
            ack_a_d = 1'b1;
            state_d = ST_IDLE;
          end else if (op_q.rnum == shadow_sel) begin
            b_done = 1'b1;
          end else begin
            state_d = ST_RESTORE;
          end
        end
      end
      ST_RESTORE: begin
        ay_da  = {4'h0, shadow_sel};
        addr_s = 1'b1;
        if (en) b_done = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (b_done) begin
      state_d = ST_IDLE;
      if (op_q.kind == OP_MUTE) mute_ack = 1'b1;
      else                      ack_b_d  = 1'b1;
    end
  end

  assign ay_addr0 = addr_s & ~op_q.sel;
  assign ay_addr1 = addr_s &  op_q.sel;
  assign ay_we0   = we_s   & ~op_q.sel;
  assign ay_we1   = we_s   &  op_q.sel;
  assign ack_a    = ack_a_q;
  assign ack_b    = ack_b_q;

  always_ff @(posedge clk28) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      cpu_reg0_q <= '0;
      cpu_reg1_q <= '0;
      ack_a_q    <= 1'b0;
      ack_b_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cpu_reg0_q <= cpu_reg0_d;
      cpu_reg1_q <= cpu_reg1_d;
      ack_a_q    <= ack_a_d;
      ack_b_q    <= ack_b_d;
    end
  end

endmodule

// File: tb/tb_ay_bus_sched.sv
// Directed bench for ay_bus_sched; inputs driven and outputs sampled on negedge.
module tb_ay_bus_sched;

  logic       clk28 = 1'b0;
  logic       rst_n, en, req_a, a_sel, a_is_addr, req_b, b_sel, mute_req;
  logic [7:0] a_d, b_data, ay_da;
  logic [3:0] b_reg;
  logic       ack_a, ack_b, ay_addr0, ay_addr1, ay_we0, ay_we1, busy;
  int         checks = 0;
  int         failures = 0;

  always #5 clk28 = ~clk28;

  ay_bus_sched dut (
    .clk28     (clk28),
    .rst_n     (rst_n),
    .en        (en),
    .req_a     (req_a),
    .a_sel     (a_sel),
    .a_is_addr (a_is_addr),
    .a_d       (a_d),
    .ack_a     (ack_a),
    .req_b     (req_b),
    .b_sel     (b_sel),
    .b_reg     (b_reg),
    .b_data    (b_data),
    .ack_b     (ack_b),
    .mute_req  (mute_req),
    .ay_da     (ay_da),
    .ay_addr0  (ay_addr0),
    .ay_addr1  (ay_addr1),
    .ay_we0    (ay_we0),
    .ay_we1    (ay_we1),
    .busy      (busy)
  );

  task automatic step();
    @(negedge clk28);
  endtask

  // Compares {da, addr0, addr1, we0, we1, ack_a, ack_b, busy}.
  task automatic bus(input string tag, input logic [7:0] da,
                     input logic a0, input logic a1, input logic w0, input logic w1,
                     input logic aa, input logic ab, input logic bz);
    logic [14:0] obs, exp;
    obs = {ay_da, ay_addr0, ay_addr1, ay_we0, ay_we1, ack_a, ack_b, busy};
    exp = {da, a0, a1, w0, w1, aa, ab, bz};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; mute_req = 1'b0;
    req_a = 1'b0; a_sel = 1'b0; a_is_addr = 1'b0; a_d = 8'h00;
    req_b = 1'b0; b_sel = 1'b0; b_reg = 4'h0; b_data = 8'h00;
    step(); step();
    bus("reset", 8'hFF, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    bus("idle", 8'hFF, 0, 0, 0, 0, 0, 0, 0);

    // A address op, chip1, en every 4th cycle
    en = 1'b0; req_a = 1'b1; a_sel = 1'b1; a_is_addr = 1'b1; a_d = 8'h07;
    step(); bus("a_addr_ph", 8'h07, 0, 1, 0, 0, 0, 0, 1);
    a_d = 8'hAA; a_sel = 1'b0;
    step(); bus("a_addr_hold1", 8'h07, 0, 1, 0, 0, 0, 0, 1);
    step(); bus("a_addr_hold2", 8'h07, 0, 1, 0, 0, 0, 0, 1);
    en = 1'b1;
    step(); bus("a_addr_ack", 8'hFF, 0, 0, 0, 0, 1, 0, 0);
    req_a = 1'b0;
    step(); bus("a_addr_ack_pulse", 8'hFF, 0, 0, 0, 0, 0, 0, 0);

    // A data op, chip0
    req_a = 1'b1; a_sel = 1'b0; a_is_addr = 1'b0; a_d = 8'h3F;
    step(); bus("a_data_ph", 8'h3F, 0, 0, 1, 0, 0, 0, 1);
    step(); bus("a_data_ack", 8'hFF, 0, 0, 0, 0, 1, 0, 0);
    req_a = 1'b0;
    step(); bus("a_data_idle", 8'hFF, 0, 0, 0, 0, 0, 0, 0);

    // latch R7 on chip0
    req_a = 1'b1; a_sel = 1'b0; a_is_addr = 1'b1; a_d = 8'h07;
    step(); bus("a_addr0_ph", 8'h07, 1, 0, 0, 0, 0, 0, 1);
    step(); bus("a_addr0_ack", 8'hFF, 0, 0, 0, 0, 1, 0, 0);
    req_a = 1'b0;

    // B op chip0 R8 with restore of R7
    req_b = 1'b1; b_sel = 1'b0; b_reg = 4'd8; b_data = 8'h0F;
    step(); bus("b_addr", 8'h08, 1, 0, 0, 0, 0, 0, 1);
    b_reg = 4'd2; b_data = 8'h55;
    step(); bus("b_data", 8'h0F, 0, 0, 1, 0, 0, 0, 1);
    step(); bus("b_restore", 8'h07, 1, 0, 0, 0, 0, 0, 1);
    step(); bus("b_ack", 8'hFF, 0, 0, 0, 0, 0, 1, 0);
    req_b = 1'b0;

    // B op chip0 R7: restore skipped
    req_b = 1'b1; b_sel = 1'b0; b_reg = 4'd7; b_data = 8'h11;
    step(); bus("b7_addr", 8'h07, 1, 0, 0, 0, 0, 0, 1);
    step(); bus("b7_data", 8'h11, 0, 0, 1, 0, 0, 0, 1);
    step(); bus("b7_ack_norestore", 8'hFF, 0, 0, 0, 0, 0, 1, 0);
    req_b = 1'b0;

    // B op chip1 R3: restores chip1 shadow R7
    req_b = 1'b1; b_sel = 1'b1; b_reg = 4'd3; b_data = 8'h22;
    step(); bus("b1_addr", 8'h03, 0, 1, 0, 0, 0, 0, 1);
    step(); bus("b1_data", 8'h22, 0, 0, 0, 1, 0, 0, 1);
    step(); bus("b1_restore", 8'h07, 0, 1, 0, 0, 0, 0, 1);
    step(); bus("b1_ack", 8'hFF, 0, 0, 0, 0, 0, 1, 0);
    req_b = 1'b0;

    // simultaneous A (chip1 data) and B (chip0 R9)
    req_a = 1'b1; a_sel = 1'b1; a_is_addr = 1'b0; a_d = 8'h5A;
    req_b = 1'b1; b_sel = 1'b0; b_reg = 4'd9; b_data = 8'h66;
    step(); bus("sim_a_data", 8'h5A, 0, 0, 0, 1, 0, 0, 1);
    step(); bus("sim_a_ack", 8'hFF, 0, 0, 0, 0, 1, 0, 0);
    req_a = 1'b0;
    step(); bus("sim_b_addr", 8'h09, 1, 0, 0, 0, 0, 0, 1);
    b_sel = 1'b1; b_reg = 4'hC; b_data = 8'h99;
    step(); bus("sim_b_data", 8'h66, 0, 0, 1, 0, 0, 0, 1);
    step(); bus("sim_b_restore", 8'h07, 1, 0, 0, 0, 0, 0, 1);
    step(); bus("sim_b_ack", 8'hFF, 0, 0, 0, 0, 0, 1, 0);
    req_b = 1'b0;

    // reset during B data phase, then re-serve with cleared shadow
    req_b = 1'b1; b_sel = 1'b0; b_reg = 4'd8; b_data = 8'h0F;
    step(); bus("rst_b_addr", 8'h08, 1, 0, 0, 0, 0, 0, 1);
    step(); bus("rst_b_data", 8'h0F, 0, 0, 1, 0, 0, 0, 1);
    rst_n = 1'b0;
    step(); bus("rst_abort", 8'hFF, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(); bus("rst_reserve_addr", 8'h08, 1, 0, 0, 0, 0, 0, 1);
    step(); bus("rst_reserve_data", 8'h0F, 0, 0, 1, 0, 0, 0, 1);
    step(); bus("rst_reserve_restore0", 8'h00, 1, 0, 0, 0, 0, 0, 1);
    step(); bus("rst_reserve_ack", 8'hFF, 0, 0, 0, 0, 0, 1, 0);
    req_b = 1'b0;
    step(); bus("rst_reserve_idle", 8'hFF, 0, 0, 0, 0, 0, 0, 0);

`ifdef AY_MUTE_EN
    mute_req = 1'b1;
    step(); bus("mute_pending", 8'hFF, 0, 0, 0, 0, 0, 0, 1);
    mute_req = 1'b0;
    step(); bus("mute0_addr", 8'h08, 1, 0, 0, 0, 0, 0, 1);
    req_a = 1'b1; a_sel = 1'b1; a_is_addr = 1'b0; a_d = 8'h77;
    step(); bus("mute0_data", 8'h00, 0, 0, 1, 0, 0, 0, 1);
    step(); bus("mute0_restore", 8'h00, 1, 0, 0, 0, 0, 0, 1);
    step(); bus("mute0_idle", 8'hFF, 0, 0, 0, 0, 0, 0, 1);
    step(); bus("mute_a_data", 8'h77, 0, 0, 0, 1, 0, 0, 1);
    step(); bus("mute_a_ack", 8'hFF, 0, 0, 0, 0, 1, 0, 1);
    req_a = 1'b0;
    for (int k = 1; k < 6; k++) begin
      logic       s;
      logic [7:0] r;
      s = (k >= 3);
      r = 8'd8 + 8'(k % 3);
      step(); bus("mute_addr", r, ~s, s, 0, 0, 0, 0, 1);
      step(); bus("mute_data", 8'h00, 0, 0, ~s, s, 0, 0, 1);
      step(); bus("mute_restore", 8'h00, ~s, s, 0, 0, 0, 0, 1);
      step(); bus("mute_idle", 8'hFF, 0, 0, 0, 0, 0, 0, (k < 5));
    end
    step(); bus("mute_done", 8'hFF, 0, 0, 0, 0, 0, 0, 0);
`else
    mute_req = 1'b1;
    step(); bus("mute_ignored", 8'hFF, 0, 0, 0, 0, 0, 0, 0);
    mute_req = 1'b0;
    step(); bus("mute_ignored2", 8'hFF, 0, 0, 0, 0, 0, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ay_bus_sched.md
# ay_bus_sched

Register-write scheduler for the two YM2149 cores of the TurboSound pair. It shares their bus-control pins between two requesters:
- the CPU port path, which has priority;
- an internal requester such as a hardware player or config engine.

Every access is serialised into address-latch and data-write phases paced by the YM clock enable. After each internal access, the block restores the CPU's latched register so CPU reads and writes of the current register stay coherent.

## Interface
Parameters: none.
- clk28  in  1  system clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- en  in  1  YM clock-enable strobe; every phase transition occurs only on a clk28 cycle with en=1
- req_a  in  1  CPU request, level, held until ack_a
- a_sel  in  1  target chip (0/1)
- a_is_addr  in  1  1 = address-latch op, 0 = data write to currently latched register
- a_d  in  8  register number (low 4 bits used) or data
- ack_a  out  1  one-cycle completion pulse
- req_b  in  1  internal request, level, held until ack_b
- b_sel  in  1  target chip
- b_reg  in  4  register number
- b_data  in  8  data
- ack_b  out  1  one-cycle completion pulse
- mute_req  in  1  mute trigger, rising-edge sensitive (see Configuration)
- ay_da  out  8  data/address to both YM I_DA
- ay_addr0, ay_addr1  out  1 each  busctrl_addr per chip
- ay_we0, ay_we1  out  1 each  busctrl_we per chip
- busy  out  1  state != IDLE

## Operation
- Shadow registers cpu_reg0 and cpu_reg1 (4 bits each) track the last CPU-latched register per chip.
- States: IDLE, ADDR, DATA, RESTORE.
- Grant (IDLE only), priority A > mute > B. On grant, capture sel, reg and data into internal registers; requester inputs are don't-care after grant.
- A address op: ADDR(a_d[3:0]), update cpu_reg[a_sel], then IDLE with ack_a.
- A data op: DATA(a_d), then IDLE with ack_a.
- B op: ADDR(b_reg), DATA(b_data), then RESTORE(cpu_reg[b_sel]), then IDLE with ack_b.
  - RESTORE is skipped when b_reg == cpu_reg[b_sel].
- Phase outputs (only the selected chip's strobe is driven):
  - ADDR: ay_da={4'h0,reg}, ay_addrN=1.
  - DATA: ay_da=data, ay_weN=1.
  - RESTORE: ay_da={4'h0,shadow}, ay_addrN=1.
- Each phase state is left on the first cycle with en=1 at or after entry, so every strobe spans ≥1 en cycle.
- ack_x is registered and pulses in the first cycle back in IDLE. The grant is evaluated in that same cycle; a requester that has not dropped req is regranted.
- No preemption: A arriving during a B sequence waits for IDLE.
- en held low: the sequence stalls with outputs frozen.

## Timing
- Reset values: state IDLE, ay_da=8'hFF, all strobes 0, acks 0, busy 0, shadows 0, mute sequencer idle.
- Reset mid-sequence: abort immediately; no ack is issued; shadows cleared (matches YM reset address 0).
- Request seen in IDLE at cycle t → strobe asserted at t+1.
- Latency from grant to ack, with en every cycle: A ops 3 cycles; B ops 4 cycles (5 with RESTORE).
- Simultaneous req_a and req_b: A granted; B is granted at the next IDLE after ack_a, unless req_a is reasserted.
- In IDLE, ay_da=8'hFF and all strobes are 0.

## Configuration
- AY_MUTE_EN defined: a rising edge of mute_req queues six writes of 8'h00: chip0 R8, R9, R10, then chip1 R8, R9, R10.
  - Each write runs as a B-style op (ADDR/DATA/RESTORE) at mute priority.
  - A requests may interleave between the six writes.
  - An edge arriving while a mute sequence is pending restarts the count at the first write.
  - busy also covers pending mute writes.
- AY_MUTE_EN undefined: the mute_req port remains but is ignored; no mute logic is synthesised.

## Structure
- Shared package ay_pkg:
  - state enum ay_sched_state_t;
  - constants AY_REG_VOL_A=4'd8, AY_REG_VOL_B=4'd9, AY_REG_VOL_C=4'd10;
  - op struct {sel, reg, data, kind}.
- One sub-module, ay_mute_seq: edge detect, 3-bit write counter, and a req/ack interface toward the scheduler's mute slot. It is instantiated only under AY_MUTE_EN.

## Test plan
- Reset, then A address op (sel=1, a_d=8'h07) with en every 4th cycle → ay_addr1 high carrying ay_da=8'h07 until the next en cycle; ack_a one pulse; cpu_reg1=7.
- A data op (sel=0, a_d=8'h3F) → ay_we0 only, ay_da=8'h3F, ack_a; ay_addr0/1 never asserted.
- Given cpu_reg0=7, B op (sel=0, reg=4'd8, data=8'h0F) → ADDR 8, DATA 8'h0F, RESTORE ay_da=8'h07 on ay_addr0, then ack_b; with reg=7 the RESTORE phase is absent.
- req_a and req_b raised in the same cycle → A sequence completes first, then B; no strobe overlap; B inputs changed after grant do not affect the output.
- rst_n low during the DATA phase of a B op → next cycle all outputs at reset values, no ack_b; request re-served after reset.
- AY_MUTE_EN, mute_req pulse with an A request mid-sequence → six writes of 8'h00 to chip0/1 R8–R10 in order, A serviced between them, busy falls after the last write.
